// File: rtl/pdp8l_iop_pkg.sv
// Shared types for the PDP-8/L IOP sequencer: FSM states, IOP line indices, IOT opcode.
// Latency: none (package).
// Backpressure: none (package).
package pdp8l_iop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_HOLD,
    ST_STOP
  } iop_state_e;

  localparam int IOP1 = 0;
  localparam int IOP2 = 1;
  localparam int IOP4 = 2;

  localparam logic [2:0] IOT_MAJOR = 3'o6;

  // Fixed priority IOP1 > IOP2 > IOP4 among the requesting lines.
  function automatic logic [1:0] iop_pick(input logic [2:0] req);
    logic [1:0] idx;
    idx = 2'(IOP4);
    if (req[IOP2]) idx = 2'(IOP2);
    if (req[IOP1]) idx = 2'(IOP1);
    return idx;
  endfunction

  function automatic logic [2:0] iop_onehot(input logic [1:0] idx);
    return 3'(3'b001 << idx);
  endfunction

endpackage

// File: rtl/pdp8l_sync_filter.sv
// Two-flop synchroniser plus debounce filter for one asynchronous IOP line.
// Latency: raw edge -> filt_o edge is 2+DEBOUNCE clocks.
// Backpressure: none; samples every clock.
module pdp8l_sync_filter #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_o,
  output logic filt_o
);

  logic [1:0] sync_q, sync_d;
  logic [3:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == 4'(DEBOUNCE - 1)) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Synchroniser is left unreset so it tracks the real line level through RESET.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign sync_o = sync_q[1];
  assign filt_o = filt_q;

endmodule

// File: rtl/pdp8l_iop_sequencer.sv
// PDP-8/L IOT front end: debounced IOP1/2/4 -> one iopstart/iopstop pair per pulse (IOP_TIMEOUT_EN adds a HOLD timeout).
// Latency: iopstart on the first CSTEP edge after the filtered rise; iopstop on the first CSTEP edge after the filtered fall.
// Backpressure: none; the FSM only advances on CSTEP, filters run every CLOCK.
module pdp8l_iop_sequencer
  import pdp8l_iop_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CSTEP,
  input  logic        iop1_in,
  input  logic        iop2_in,
  input  logic        iop4_in,
  input  logic [11:0] mb_in,
  input  logic [11:0] ac_in,
  input  logic        clrerr,
  output logic        iopstart,
  output logic        iopstop,
  output logic [11:0] ioopcode,
  output logic [11:0] cputodev,
  output logic        ioperr
);

  if (DEBOUNCE < 1 || DEBOUNCE > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("pdp8l_iop_sequencer: DEBOUNCE must be 1..15 and TIMEOUT >= 1");
  end

  logic [2:0]  raw_lvl, sync_lvl, filt_lvl;
  iop_state_e  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  arm_q, arm_d;
  logic [11:0] ioopcode_q, ioopcode_d;
  logic [11:0] cputodev_q, cputodev_d;
  logic        ioperr_q, ioperr_d;
  logic [2:0]  req, other;
  logic [1:0]  pick;
  logic        busy, err_set, overlap, sel_high;

  assign raw_lvl = {iop4_in, iop2_in, iop1_in};

  for (genvar i = 0; i < 3; i++) begin : g_line
    pdp8l_sync_filter #(.DEBOUNCE(DEBOUNCE)) u_filt (
      .clk    (CLOCK),
      .rst    (RESET),
      .din    (raw_lvl[i]),
      .sync_o (sync_lvl[i]),
      .filt_o (filt_lvl[i])
    );
  end

`ifdef IOP_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_hit;

  assign tmo_hit = (tmo_q >= 16'(TIMEOUT));

  always_comb begin
    tmo_d = '0;
    if (state_q == ST_HOLD) tmo_d = tmo_hit ? tmo_q : tmo_q + 16'd1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    arm_d      = arm_q;
    ioopcode_d = ioopcode_q;
    cputodev_d = cputodev_q;
    err_set    = 1'b0;

    // A line may start a sequence only after it has been seen low (arm).
    req      = filt_lvl & arm_q;
    pick     = iop_pick(req);
    overlap  = (filt_lvl[0] & filt_lvl[1]) | (filt_lvl[0] & filt_lvl[2]) | (filt_lvl[1] & filt_lvl[2]);
    busy     = (state_q == ST_START) || (state_q == ST_HOLD);
    other    = req & ~iop_onehot(sel_q);
    sel_high = |(filt_lvl & iop_onehot(sel_q));

    if (busy && (|other)) err_set = 1'b1;

    if (CSTEP) begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            sel_d      = pick;
            ioopcode_d = {mb_in[11:3], mb_in[2:0] & iop_onehot(pick)};
            cputodev_d = ac_in;
            state_d    = ST_START;
            if (overlap) err_set = 1'b1;
          end
        end
        ST_START: state_d = ST_HOLD;
        ST_HOLD: begin
          if (!sel_high) begin
            state_d = ST_STOP;
`ifdef IOP_TIMEOUT_EN
          end else if (tmo_hit) begin
            state_d = ST_STOP;
            err_set = 1'b1;
`endif
          end
        end
        ST_STOP: begin
          state_d    = ST_IDLE;
          ioopcode_d = '0;
          cputodev_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Lines high while a sequence is in flight are ignored until they drop.
    for (int i = 0; i < 3; i++) begin
      if (!filt_lvl[i] && !sync_lvl[i]) arm_d[i] = 1'b1;
      else if (filt_lvl[i] && busy)     arm_d[i] = 1'b0;
    end

    ioperr_d = err_set ? 1'b1 : (clrerr ? 1'b0 : ioperr_q);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      arm_q      <= '0;
      ioopcode_q <= '0;
      cputodev_q <= '0;
      ioperr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      arm_q      <= arm_d;
      ioopcode_q <= ioopcode_d;
      cputodev_q <= cputodev_d;
      ioperr_q   <= ioperr_d;
    end
  end

  assign iopstart = (state_q == ST_START);
  assign iopstop  = (state_q == ST_STOP);
  assign ioopcode = ioopcode_q;
  assign cputodev = cputodev_q;
  assign ioperr   = ioperr_q;

endmodule

// File: tb/tb_pdp8l_iop_sequencer.sv
// Bench for pdp8l_iop_sequencer: directed scenarios plus randomized IOP traffic against a behavioural model.
module tb_pdp8l_iop_sequencer;
  localparam int D = 3;
  localparam int T = 50;

  logic        CLOCK = 1'b0, RESET = 1'b1, CSTEP = 1'b1, clrerr = 1'b0;
  logic        iop1_in = 1'b0, iop2_in = 1'b0, iop4_in = 1'b0;
  logic [11:0] mb_in = '0, ac_in = '0;
  logic        iopstart, iopstop, ioperr;
  logic [11:0] ioopcode, cputodev;

  int total = 0, bad = 0, cyc = 0, cstep_mode = 0;
  bit chk_en = 1'b0;

  pdp8l_iop_sequencer #(.DEBOUNCE(D), .TIMEOUT(T)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP),
    .iop1_in(iop1_in), .iop2_in(iop2_in), .iop4_in(iop4_in),
    .mb_in(mb_in), .ac_in(ac_in), .clrerr(clrerr),
    .iopstart(iopstart), .iopstop(iopstop),
    .ioopcode(ioopcode), .cputodev(cputodev), .ioperr(ioperr)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0o want %0o (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rh[i][k]: raw level of line i sampled k edges ago; the synchronised level seen
  // by the filter at an edge is the raw sample from two edges earlier.
  bit          rh [3][0:20];
  int          nr = 0;
  bit   [2:0]  mf = '0, marm = '0;
  int          mph = 0, msel = 0, mhold = 0;
  logic [11:0] mop = '0, mac = '0;
  bit          merr = 1'b0;

  always @(posedge CLOCK) begin : model
    bit [2:0] raw, f_old, a_old;
    int ph_old, pick;
    bit eset, stable, tmo;
    raw = {iop4_in, iop2_in, iop1_in};
    for (int i = 0; i < 3; i++) begin
      for (int k = 20; k > 0; k--) rh[i][k] = rh[i][k-1];
      rh[i][0] = raw[i];
    end
    nr = RESET ? 0 : nr + 1;
    f_old = mf; a_old = marm; ph_old = mph; tmo = 1'b0;
    if (RESET) begin
      mf = '0; marm = '0; mph = 0; mop = '0; mac = '0; merr = 1'b0; mhold = 0;
    end else begin
`ifdef IOP_TIMEOUT_EN
      tmo   = (ph_old == 2) && (mhold >= T);
      mhold = (ph_old == 2) ? mhold + 1 : 0;
`endif
      for (int i = 0; i < 3; i++) begin
        // filtered level flips once the last D post-reset samples all disagree with it
        stable = (nr >= D);
        for (int j = 2; j < D + 2; j++) if (rh[i][j] == f_old[i]) stable = 1'b0;
        if (stable) mf[i] = !f_old[i];
        if (!f_old[i] && !rh[i][2]) marm[i] = 1'b1;
        else if (f_old[i] && (ph_old == 1 || ph_old == 2)) marm[i] = 1'b0;
      end
      eset = 1'b0;
      if (ph_old == 1 || ph_old == 2)
        for (int i = 0; i < 3; i++) if (i != msel && f_old[i] && a_old[i]) eset = 1'b1;
      if (CSTEP) begin
        case (ph_old)
          0: begin
            pick = -1;
            for (int i = 2; i >= 0; i--) if (f_old[i] && a_old[i]) pick = i;
            if (pick >= 0) begin
              msel = pick;
              mop  = (mb_in & 12'o7770) | (mb_in & 12'(1 << pick));
              mac  = ac_in;
              mph  = 1;
              if ($countones(f_old) > 1) eset = 1'b1;
            end
          end
          1: mph = 2;
          2: begin
            if (!f_old[msel]) mph = 3;
            else if (tmo) begin mph = 3; eset = 1'b1; end
          end
          default: begin mph = 0; mop = '0; mac = '0; end
        endcase
      end
      if (eset) merr = 1'b1;
      else if (clrerr) merr = 1'b0;
    end
  end

  always @(negedge CLOCK) begin
    if (chk_en) begin
      chk("iopstart", int'(iopstart), int'(mph == 1));
      chk("iopstop",  int'(iopstop),  int'(mph == 3));
      chk("ioopcode", int'(ioopcode), int'(mop));
      chk("cputodev", int'(cputodev), int'(mac));
      chk("ioperr",   int'(ioperr),   int'(merr));
    end
  end

  // ---------------- event monitor for literal checks ----------------
  int n_start = 0, n_stop = 0, start_w = 0, stop_w = 0, stop_cyc = 0;
  logic [11:0] last_op = '0, last_ac = '0;
  logic [11:0] op_log[$];
  bit prev_s = 1'b0, prev_p = 1'b0;

  always @(negedge CLOCK) begin
    if (iopstart && !prev_s) begin
      n_start++; last_op = ioopcode; last_ac = cputodev; op_log.push_back(ioopcode);
    end
    if (iopstop && !prev_p) begin n_stop++; stop_cyc = cyc; end
    if (iopstart) start_w++;
    if (iopstop)  stop_w++;
    prev_s = iopstart; prev_p = iopstop;
  end

  initial begin : cstep_gen
    forever begin
      @(negedge CLOCK);
      case (cstep_mode)
        0:       CSTEP = 1'b1;
        1:       CSTEP = ((cyc % 4) == 0);
        default: CSTEP = 1'($urandom % 2);
      endcase
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  task automatic clk(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic set_line(input int k, input logic v);
    case (k)
      0:       iop1_in = v;
      1:       iop2_in = v;
      default: iop4_in = v;
    endcase
  endtask

  initial begin : main
    int s0, p0, sw0, pw0, fall;
    int off[3], len[3];
    int rst_at, mask;

    RESET = 1'b1;
    clk(5);
    chk_en = 1'b1;
    #2;
    chk("rst_iopstart", int'(iopstart), 0);
    chk("rst_iopstop",  int'(iopstop), 0);
    chk("rst_ioopcode", int'(ioopcode), 0);
    chk("rst_cputodev", int'(cputodev), 0);
    chk("rst_ioperr",   int'(ioperr), 0);
    clk(1);
    RESET = 1'b0;
    clk(5);

    // 1: single IOP4 pulse
    mb_in = 12'o6764; ac_in = 12'o0205; s0 = n_start; p0 = n_stop;
    iop4_in = 1'b1; clk(20); iop4_in = 1'b0; fall = cyc; clk(20); #2;
    chk("t1_starts", n_start - s0, 1);
    chk("t1_op", int'(last_op), 12'o6764);
    chk("t1_ac", int'(last_ac), 12'o0205);
    chk("t1_stops", n_stop - p0, 1);
    chk("t1_stop_latency", stop_cyc - fall, D + 3);
    chk("t1_op_idle", int'(ioopcode), 0);
    chk("t1_ac_idle", int'(cputodev), 0);

    // 2: IOP1, IOP2, IOP4 of one IOT
    @(negedge CLOCK);
    mb_in = 12'o6767; op_log.delete(); s0 = n_start;
    for (int k = 0; k < 3; k++) begin
      set_line(k, 1'b1); clk(10); set_line(k, 1'b0); clk(15);
    end
    #2;
    chk("t2_starts", n_start - s0, 3);
    chk("t2_op1", (op_log.size() > 0) ? int'(op_log[0]) : -1, 12'o6761);
    chk("t2_op2", (op_log.size() > 1) ? int'(op_log[1]) : -1, 12'o6762);
    chk("t2_op4", (op_log.size() > 2) ? int'(op_log[2]) : -1, 12'o6764);
    chk("t2_err", int'(ioperr), 0);

    // 3: glitch shorter than the debounce window
    @(negedge CLOCK);
    s0 = n_start;
    iop1_in = 1'b1; clk(D - 1); iop1_in = 1'b0; clk(15); #2;
    chk("t3_starts", n_start - s0, 0);
    chk("t3_err", int'(ioperr), 0);

    // 4: IOP1 and IOP2 together
    @(negedge CLOCK);
    mb_in = 12'o6773; s0 = n_start;
    iop1_in = 1'b1; iop2_in = 1'b1; clk(10); iop1_in = 1'b0; iop2_in = 1'b0; clk(15); #2;
    chk("t4_starts", n_start - s0, 1);
    chk("t4_op", int'(last_op), 12'o6771);
    chk("t4_err_set", int'(ioperr), 1);
    @(negedge CLOCK); clrerr = 1'b1; clk(1); clrerr = 1'b0; #2;
    chk("t4_err_clr", int'(ioperr), 0);

    // 5: CSTEP every 4th clock
    @(negedge CLOCK);
    cstep_mode = 1; clk(4);
    s0 = n_start; p0 = n_stop; sw0 = start_w; pw0 = stop_w;
    iop2_in = 1'b1; clk(12); iop2_in = 1'b0; clk(30); #2;
    chk("t5_starts", n_start - s0, 1);
    chk("t5_stops", n_stop - p0, 1);
    chk("t5_start_width", start_w - sw0, 4);
    chk("t5_stop_width", stop_w - pw0, 4);
    @(negedge CLOCK); cstep_mode = 0; clk(4);

    // 6: RESET during HOLD with IOP2 still high
    s0 = n_start; p0 = n_stop;
    iop2_in = 1'b1; clk(10); RESET = 1'b1; clk(3); RESET = 1'b0; clk(30); #2;
    chk("t6_no_stop", n_stop - p0, 0);
    chk("t6_no_restart", n_start - s0, 1);
    @(negedge CLOCK);
    iop2_in = 1'b0; clk(15); iop2_in = 1'b1; clk(10); iop2_in = 1'b0; clk(15); #2;
    chk("t6_rearm_starts", n_start - s0, 2);
    chk("t6_rearm_stops", n_stop - p0, 1);

`ifdef IOP_TIMEOUT_EN
    // 6b: stuck line forced out after TIMEOUT
    @(negedge CLOCK);
    s0 = n_start; p0 = n_stop;
    iop2_in = 1'b1; clk(80); #2;
    chk("t6b_tmo_stop", n_stop - p0, 1);
    chk("t6b_tmo_err", int'(ioperr), 1);
    clk(20); #2;
    chk("t6b_no_retrigger", n_start - s0, 1);
    @(negedge CLOCK);
    iop2_in = 1'b0; clk(15); clrerr = 1'b1; clk(1); clrerr = 1'b0; clk(2);
`endif

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      @(negedge CLOCK);
      cstep_mode = $urandom_range(0, 2);
      mb_in = ($urandom % 4 == 0) ? 12'($urandom) : {3'o6, 9'($urandom)};
      ac_in = 12'($urandom);
      mask  = ($urandom % 3 != 0) ? (1 << $urandom_range(0, 2)) : $urandom_range(1, 7);
      for (int i = 0; i < 3; i++) begin
        off[i] = $urandom_range(0, 12);
        len[i] = ((mask >> i) & 1) != 0 ? $urandom_range(1, 30) : 0;
      end
      rst_at = (it % 23 == 11) ? $urandom_range(0, 30) : -1;
      for (int c = 0; c < 45; c++) begin
        for (int i = 0; i < 3; i++) set_line(i, (c >= off[i]) && (c < off[i] + len[i]));
        RESET  = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 2);
        clrerr = ($urandom % 50 == 0);
        clk(1);
      end
      iop1_in = 1'b0; iop2_in = 1'b0; iop4_in = 1'b0; RESET = 1'b0; clrerr = 1'b0;
      clk($urandom_range(0, 15));
    end
    cstep_mode = 0;
    clk(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
